fir_param_stream: RTL and testbench

FIR_PARAM_STREAM -- requirements
Module: fir_param_stream

---
 rtl/fir_param_stream.sv | 134 +++++++++++++
 tb/tb_fir_param_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_param_stream: one-MAC-per-cycle streaming FIR with shift-loaded taps;   |
// | define FIR_PARAM_SAT_EN to clamp output instead of wrapping. Rev 1.0        |
// +----------------------------------------------------------------------------+
module fir_param_stream #(
   parameter int NTAPS = 8,
   parameter int X_W   = 8,
   parameter int C_W   = 8,
   parameter int Y_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_coef_load,
   input  logic signed [C_W-1:0] i_coef_in,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   input  logic signed [X_W-1:0] i_s_data,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic signed [Y_W-1:0] o_m_data
);

   localparam int ACC_W = X_W + C_W + $clog2(NTAPS);
   localparam int IDX_W = $clog2(NTAPS);
   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NTAPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic signed [C_W-1:0]   r_coef [NTAPS];
   logic signed [X_W-1:0]   r_x    [NTAPS];
   logic signed [ACC_W-1:0] r_acc;
   logic [IDX_W-1:0]        r_tap;
   logic                    r_mac_done;
   logic                    r_m_valid;
   logic signed [Y_W-1:0]   r_m_data;
   logic                    w_s_ready;
   logic                    w_accept;
   logic                    w_coef_shift;
   logic signed [X_W+C_W-1:0] w_prod;
   logic signed [Y_W-1:0]   w_y;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_s_ready    = 1'b0;
      w_accept     = 1'b0;
      w_coef_shift = 1'b0;
      case (r_state)
         IDLE: begin
            w_s_ready    = !i_coef_load && !reset;
            w_coef_shift = i_coef_load;
            w_accept     = i_s_valid && w_s_ready;
            if (w_accept) w_next = MAC;
         end
         MAC:     if (r_mac_done) w_next = HOLD;
         HOLD:    if (i_m_ready)  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_prod = r_coef[r_tap] * r_x[r_tap];

`ifdef FIR_PARAM_SAT_EN
   // Result fits when every bit above the output sign bit matches it.
   logic [ACC_W-Y_W:0] w_hi;
   logic               w_fits;
   assign w_hi   = r_acc[ACC_W-1:Y_W-1];
   assign w_fits = (&w_hi) | ~(|w_hi);
   always_comb begin
      w_y = r_acc[Y_W-1:0];
      if (!w_fits)
         w_y = r_acc[ACC_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
   end
`else
   logic w_unused_acc;
   assign w_unused_acc = ^r_acc;
   assign w_y          = r_acc[Y_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++) begin
            r_coef[k] <= '0;
            r_x[k]    <= '0;
         end
         r_acc      <= '0;
         r_tap      <= '0;
         r_mac_done <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
      end else begin
         if (w_coef_shift) begin
            r_coef[0] <= i_coef_in;
            for (int k = 1; k < NTAPS; k++) r_coef[k] <= r_coef[k-1];
         end
         if (w_accept) begin
            r_x[0] <= i_s_data;
            for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
            r_acc      <= '0;
            r_tap      <= '0;
            r_mac_done <= 1'b0;
         end
         // Products run for NTAPS cycles; the following cycle registers the result.
         if (r_state == MAC && !r_mac_done) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            if (r_tap == c_LAST) r_mac_done <= 1'b1;
            else                 r_tap      <= r_tap + IDX_W'(1);
         end
         if (r_state == MAC && r_mac_done) begin
            r_m_data  <= w_y;
            r_m_valid <= 1'b1;
         end
         if (r_state == HOLD && i_m_ready) r_m_valid <= 1'b0;
      end
   end

   assign o_s_ready = w_s_ready;
   assign o_m_valid = r_m_valid;
   assign o_m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_fir_param_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_param_stream: directed and random checks against a sum-of-products   |
// | reference model (NTAPS=4, 8-bit in/coef, 16-bit out). Rev 1.0               |
// +----------------------------------------------------------------------------+
module tb_fir_param_stream;

   localparam int NTAPS = 4;
   localparam int X_W   = 8;
   localparam int C_W   = 8;
   localparam int Y_W   = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  i_coef_load;
   logic signed [C_W-1:0] i_coef_in;
   logic                  i_s_valid;
   logic                  o_s_ready;
   logic signed [X_W-1:0] i_s_data;
   logic                  o_m_valid;
   logic                  i_m_ready;
   logic signed [Y_W-1:0] o_m_data;

   int checks = 0;
   int errors = 0;
   int mc [NTAPS];
   int mx [NTAPS];

   fir_param_stream #(.NTAPS(NTAPS), .X_W(X_W), .C_W(C_W), .Y_W(Y_W)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_coef_load(i_coef_load),
      .i_coef_in  (i_coef_in),
      .i_s_valid  (i_s_valid),
      .o_s_ready  (o_s_ready),
      .i_s_data   (i_s_data),
      .o_m_valid  (o_m_valid),
      .i_m_ready  (i_m_ready),
      .o_m_data   (o_m_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int k = 0; k < NTAPS; k++) begin
         mc[k] = 0;
         mx[k] = 0;
      end
   endfunction

   // y = sum coef[k]*x(n-k), then saturated or wrapped to Y_W bits.
   function automatic int model_y();
      longint acc = 0;
      longint m   = longint'(1) << Y_W;
      for (int k = 0; k < NTAPS; k++) acc += longint'(mc[k]) * longint'(mx[k]);
`ifdef FIR_PARAM_SAT_EN
      if (acc > m/2 - 1) acc = m/2 - 1;
      if (acc < -(m/2))  acc = -(m/2);
`else
      acc = acc & (m - 1);
      if (acc >= m/2) acc -= m;
`endif
      return int'(acc);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      chk("ready_in_reset", o_s_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      model_clear();
      chk("reset_m_valid", o_m_valid, 0);
      chk("reset_m_data", o_m_data, 0);
      chk("ready_after_reset", o_s_ready, 1);
   endtask

   task automatic load_coef(input int c);
      i_coef_load = 1'b1;
      i_coef_in   = C_W'(c);
      tick();
      for (int k = NTAPS-1; k > 0; k--) mc[k] = mc[k-1];
      mc[0] = c;
      i_coef_load = 1'b0;
   endtask

   task automatic send_sample(input int x, input int hold, input bit cl_mac,
                              input bit keep_valid, input int nxt, output int y_obs);
      int n   = 0;
      int lat = 0;
      int exp;
      while (o_s_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("s_ready_wait", o_s_ready, 1);
      i_s_valid = 1'b1;
      i_s_data  = X_W'(x);
      tick();
      for (int k = NTAPS-1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = x;
      exp = model_y();
      i_s_valid = keep_valid;
      i_s_data  = X_W'(nxt);
      while (o_m_valid !== 1'b1 && lat < 20) begin
         i_m_ready   = 1'($urandom);
         i_coef_load = cl_mac && (lat == 1);
         i_coef_in   = C_W'($urandom);
         tick();
         lat++;
      end
      i_coef_load = 1'b0;
      chk("latency", lat, 5);
      chk("result", o_m_data, exp);
      y_obs = int'(o_m_data);
      i_m_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_valid", o_m_valid, 1);
         chk("hold_data", o_m_data, exp);
         chk("hold_ready", o_s_ready, 0);
      end
      i_m_ready = 1'b1;
      tick();
      chk("valid_drop", o_m_valid, 0);
      chk("data_keep", o_m_data, exp);
      i_m_ready = 1'b0;
   endtask

   initial begin
      int y;
      reset       = 1'b1;
      i_coef_load = 1'b0;
      i_coef_in   = '0;
      i_s_valid   = 1'b0;
      i_s_data    = '0;
      i_m_ready   = 1'b0;
      tick();

      // Impulse response through coefficients 1,2,3,4.
      do_reset();
      load_coef(4); load_coef(3); load_coef(2); load_coef(1);
      send_sample(1, 0, 1'b0, 1'b0, 0, y); chk("impulse0", y, 1);
      send_sample(0, 0, 1'b0, 1'b0, 0, y); chk("impulse1", y, 2);
      send_sample(0, 0, 1'b0, 1'b0, 0, y); chk("impulse2", y, 3);
      send_sample(0, 0, 1'b0, 1'b0, 0, y); chk("impulse3", y, 4);
      send_sample(0, 0, 1'b0, 1'b0, 0, y); chk("impulse4", y, 0);

      // Extreme values: saturate or wrap on the fourth result.
      do_reset();
      for (int k = 0; k < NTAPS; k++) load_coef(127);
      for (int k = 0; k < NTAPS; k++) send_sample(-128, 0, 1'b0, 1'b0, 0, y);
`ifdef FIR_PARAM_SAT_EN
      chk("extreme_sat", y, -32768);
`else
      chk("extreme_wrap", y, 512);
`endif

      // Backpressure with a pending sample, then that sample exactly once.
      send_sample(5, 10, 1'b0, 1'b1, -7, y);
      send_sample(-7, 0, 1'b0, 1'b0, 0, y);

      // coef_load beats s_valid in IDLE; coef_load during MAC is ignored.
      i_coef_load = 1'b1;
      i_coef_in   = 8'sd5;
      i_s_valid   = 1'b1;
      i_s_data    = 8'sd77;
      #1;
      chk("ready_vs_load", o_s_ready, 0);
      tick();
      for (int k = NTAPS-1; k > 0; k--) mc[k] = mc[k-1];
      mc[0] = 5;
      i_coef_load = 1'b0;
      i_s_valid   = 1'b0;
      tick();
      tick();
      chk("no_accept_valid", o_m_valid, 0);
      chk("no_accept_ready", o_s_ready, 1);
      send_sample(3, 0, 1'b1, 1'b0, 0, y);
      send_sample(-2, 1, 1'b1, 1'b0, 0, y);

      // Reset in the middle of MAC, then impulse with cleared coefficients.
      i_s_valid = 1'b1;
      i_s_data  = 8'sd9;
      tick();
      i_s_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("ready_during_reset", o_s_ready, 0);
      tick();
      chk("midmac_reset_valid", o_m_valid, 0);
      chk("midmac_reset_data", o_m_data, 0);
      reset = 1'b0;
      #1;
      chk("midmac_ready", o_s_ready, 1);
      model_clear();
      send_sample(1, 0, 1'b0, 1'b0, 0, y);
      chk("unloaded_impulse", y, 0);

      // Random coefficients and samples against the reference model.
      do_reset();
      for (int k = 0; k < NTAPS; k++) load_coef(int'($urandom_range(0, 255)) - 128);
      for (int t = 0; t < 24; t++)
         send_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)),
                     1'($urandom), 1'b0, 0, y);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
